// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-issue stage feeding the alu.
// Two-entry skid buffer (main + skid) between decode and the alu, so in_ready
// is a pure register output with no combinational path from out_ready.
// Optional writeback forwarding is enabled by defining ALU_ISSUE_FWD_EN;
// without it the wb_* ports are accepted but ignored.
module alu_issue_stage #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_aluop,
    input  logic [WIDTH-1:0]      in_rs1_data,
    input  logic [WIDTH-1:0]      in_rs2_data,
    input  logic [WIDTH-1:0]      in_imm,
    input  logic                  in_use_imm,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            aluop,
    output logic [WIDTH-1:0]      a,
    output logic [WIDTH-1:0]      b,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [WIDTH-1:0]      wb_data
);

    typedef struct packed {
        logic [2:0]            aluop;
        logic [WIDTH-1:0]      a;
        logic [WIDTH-1:0]      b;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  b_is_reg;
    } slot_t;

    logic  main_valid;
    logic  skid_valid;
    slot_t main_q;
    slot_t skid_q;

    slot_t cap;       // raw capture of the incoming op
    slot_t cap_f;     // capture after forwarding
    slot_t main_f;    // held main slot after writeback snoop
    slot_t skid_f;    // held skid slot after writeback snoop

    logic accept;
    logic transfer;

    assign in_ready    = !skid_valid;
    assign out_valid   = main_valid;
    assign aluop       = main_q.aluop;
    assign a           = main_q.a;
    assign b           = main_q.b;
    assign out_rd_addr = main_q.rd;

    assign accept   = in_valid && in_ready;
    assign transfer = main_valid && out_ready;

    // Build the slot image of the incoming op (operand b selected here)
    always_comb begin
        cap          = '0;
        cap.aluop    = in_aluop;
        cap.a        = in_rs1_data;
        cap.b        = in_use_imm ? in_imm : in_rs2_data;
        cap.rd       = in_rd_addr;
        cap.rs1      = in_rs1_addr;
        cap.rs2      = in_rs2_addr;
        cap.b_is_reg = !in_use_imm;
    end

`ifdef ALU_ISSUE_FWD_EN
    function automatic slot_t snoop(input slot_t s, input logic v,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic [WIDTH-1:0] data);
        slot_t r;
        r = s;
        if (v && (rd != '0)) begin
            if (s.rs1 == rd)
                r.a = data;
            if (s.b_is_reg && (s.rs2 == rd))
                r.b = data;
        end
        return r;
    endfunction

    // Apply this cycle's writeback to the capture and to both held slots;
    // a slot moving skid->main carries its snooped value with it
    always_comb begin
        cap_f  = snoop(cap,    wb_valid, wb_rd, wb_data);
        main_f = snoop(main_q, wb_valid, wb_rd, wb_data);
        skid_f = snoop(skid_q, wb_valid, wb_rd, wb_data);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_valid, wb_rd, wb_data,
                          main_q.rs1, main_q.rs2, main_q.b_is_reg};

    // Forwarding disabled: operands never change after capture
    always_comb begin
        cap_f  = cap;
        main_f = main_q;
        skid_f = skid_q;
    end
`endif

    // Main/skid slot update: skid drains into main before new input is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_q <= main_f;
            skid_q <= skid_f;
            if (transfer) begin
                if (skid_valid) begin
                    main_q     <= skid_f;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_q <= cap_f;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                if (!main_valid) begin
                    main_valid <= 1'b1;
                    main_q     <= cap_f;
                end else begin
                    skid_valid <= 1'b1;
                    skid_q     <= cap_f;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by a
// randomized run, all compared against a queue-based FIFO reference model.
// Define ALU_ISSUE_FWD_EN for both bench and design to test forwarding.
module tb_alu_issue_stage;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_aluop = '0;
    logic [W-1:0]  in_rs1_data = '0;
    logic [W-1:0]  in_rs2_data = '0;
    logic [W-1:0]  in_imm = '0;
    logic          in_use_imm = 1'b0;
    logic [AW-1:0] in_rs1_addr = '0;
    logic [AW-1:0] in_rs2_addr = '0;
    logic [AW-1:0] in_rd_addr = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    aluop;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] out_rd_addr;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_rd = '0;
    logic [W-1:0]  wb_data = '0;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.WIDTH(W), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluop(aluop), .a(a), .b(b), .out_rd_addr(out_rd_addr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          b_reg;
    } op_t;

    // Reference: ops pending in the stage, oldest first, at most two
    op_t q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic op_t fwd(input op_t e);
        op_t r;
        r = e;
`ifdef ALU_ISSUE_FWD_EN
        if (wb_valid && wb_rd != 0) begin
            if (e.rs1 == wb_rd) r.a = wb_data;
            if (e.b_reg && e.rs2 == wb_rd) r.b = wb_data;
        end
`endif
        return r;
    endfunction

    // Advance the model by one clock using the currently driven inputs,
    // wait to the next falling edge and compare the DUT against it
    task automatic tick();
        int  n;
        bit  xfer;
        bit  acc;
        op_t e;
        n    = q.size();
        xfer = (n > 0) && out_ready;
        acc  = in_valid && (n < 2);
        if (xfer) void'(q.pop_front());
        foreach (q[i]) q[i] = fwd(q[i]);
        if (acc) begin
            e.op    = in_aluop;
            e.a     = in_rs1_data;
            e.b     = in_use_imm ? in_imm : in_rs2_data;
            e.rd    = in_rd_addr;
            e.rs1   = in_rs1_addr;
            e.rs2   = in_rs2_addr;
            e.b_reg = !in_use_imm;
            q.push_back(fwd(e));
        end
        @(negedge clk);
        chk("out_valid", W'(out_valid), W'(q.size() > 0));
        chk("in_ready",  W'(in_ready),  W'(q.size() < 2));
        if (q.size() > 0) begin
            chk("aluop", W'(aluop), W'(q[0].op));
            chk("a", a, q[0].a);
            chk("b", b, q[0].b);
            chk("rd", W'(out_rd_addr), W'(q[0].rd));
        end
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [W-1:0] r1,
                            input logic [W-1:0] r2, input logic [W-1:0] imm,
                            input logic use_imm, input logic [AW-1:0] s1,
                            input logic [AW-1:0] s2, input logic [AW-1:0] rd);
        in_valid    = 1'b1;
        in_aluop    = op;
        in_rs1_data = r1;
        in_rs2_data = r2;
        in_imm      = imm;
        in_use_imm  = use_imm;
        in_rs1_addr = s1;
        in_rs2_addr = s2;
        in_rd_addr  = rd;
    endtask

    initial begin
        logic [W-1:0] exp_a;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_in_ready", W'(in_ready), 32'd1);
        chk("rst_a", a, '0);
        chk("rst_b", b, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op with immediate
        out_ready = 1'b1;
        drive_op(3'd0, 32'h800055AA, 32'h0, 32'h4, 1'b1, 5'd1, 5'd2, 5'd3);
        tick();
        chk("single_a", a, 32'h800055AA);
        chk("single_b", b, 32'h4);
        chk("single_valid", W'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("single_gone", W'(out_valid), '0);

        // Backpressure: A to main, B to skid, C held at input
        out_ready = 1'b0;
        drive_op(3'd1, 32'hA, 32'hA0, 32'h0, 1'b0, 5'd4, 5'd6, 5'd1);
        tick();
        drive_op(3'd2, 32'hB, 32'hB0, 32'h0, 1'b0, 5'd4, 5'd6, 5'd2);
        tick();
        chk("bp_in_ready", W'(in_ready), '0);
        drive_op(3'd3, 32'hC, 32'hC0, 32'h0, 1'b0, 5'd4, 5'd6, 5'd3);
        tick();
        chk("bp_hold_rd", W'(out_rd_addr), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_second_rd", W'(out_rd_addr), 32'd2);
        tick();
        chk("bp_third_rd", W'(out_rd_addr), 32'd3);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", W'(out_valid), '0);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            drive_op(3'(i), 32'(i * 17), 32'(i * 5), 32'h0, 1'b0, 5'd7, 5'd8, 5'(i));
            tick();
            chk("stream_ready", W'(in_ready), 32'd1);
            chk("stream_op", W'(aluop), W'(i));
        end
        in_valid = 1'b0;
        tick();

        // Skid full, transfer with new input offered in the same cycle
        out_ready = 1'b0;
        drive_op(3'd4, 32'h41, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd10);
        tick();
        drive_op(3'd5, 32'h51, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd11);
        tick();
        out_ready = 1'b1;
        drive_op(3'd6, 32'h61, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd12);
        tick();
        chk("simul_main_is_skid", W'(aluop), 32'd5);
        chk("simul_ready", W'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();
        tick();

        // Reset while both slots are full
        out_ready = 1'b0;
        drive_op(3'd7, 32'h71, 32'h72, 32'h0, 1'b0, 5'd1, 5'd2, 5'd13);
        tick();
        drive_op(3'd3, 32'h81, 32'h82, 32'h0, 1'b0, 5'd1, 5'd2, 5'd14);
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", W'(out_valid), '0);
        chk("mid_rst_a", a, '0);
        chk("mid_rst_b", b, '0);
        chk("mid_rst_op", W'(aluop), '0);
        chk("mid_rst_rd", W'(out_rd_addr), '0);
        chk("mid_rst_ready", W'(in_ready), 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();

        // Writeback snoop on a held op
        out_ready = 1'b0;
        drive_op(3'd2, 32'h11, 32'h22, 32'h1234, 1'b1, 5'd5, 5'd5, 5'd6);
        tick();
        in_valid = 1'b0;
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'hDEADBEEF;
        tick();
`ifdef ALU_ISSUE_FWD_EN
        exp_a = 32'hDEADBEEF;
`else
        exp_a = 32'h11;
`endif
        chk("fwd_a", a, exp_a);
        chk("fwd_b_imm", b, 32'h1234);
        wb_rd   = 5'd0;
        wb_data = 32'hCAFEF00D;
        tick();
        chk("fwd_r0_a", a, exp_a);
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        // Randomized traffic with writeback activity
        for (int i = 0; i < 400; i++) begin
            in_valid    = 1'($urandom_range(0, 3) != 0);
            in_aluop    = 3'($urandom);
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            in_imm      = $urandom;
            in_use_imm  = 1'($urandom);
            in_rs1_addr = 5'($urandom_range(0, 7));
            in_rs2_addr = 5'($urandom_range(0, 7));
            in_rd_addr  = 5'($urandom);
            out_ready   = 1'($urandom_range(0, 2) != 0);
            wb_valid    = 1'($urandom);
            wb_rd       = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
